// File: rtl/terminal_fifo_pkg.sv
// Shared register-map constants and the STATUS word layout for the terminal FIFO.
// Included by the top level so decode and read mux agree on one definition.
package terminal_fifo_pkg;

   localparam logic [7:0]  TERM_OFF_TXDATA    = 8'h00;
   localparam logic [7:0]  TERM_OFF_STATUS    = 8'h04;
   localparam logic [7:0]  TERM_OFF_CTRL      = 8'h08;
   localparam logic [7:0]  TERM_OFF_HIST      = 8'h10;

   localparam int          CTRL_CLR_OVF_BIT   = 0;
   localparam int          CTRL_FLUSH_BIT     = 1;

   localparam logic [31:0] TERM_READ_UNMAPPED = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [7:0]  count;
      logic [4:0]  rsvd_lo;
      logic        ovf;
      logic        full;
      logic        empty;
   } status_t;

   // Registers are word aligned; the two low address bits never select anything.
   function automatic logic [7:0] word_offset(input logic [7:0] byte_off);
      return byte_off & 8'hFC;
   endfunction

endpackage

// File: rtl/terminal_fifo_if.sv
// CPU data-memory bus plus the outgoing byte stream, bundled for the terminal FIFO.
// The master side is the CPU/sink environment; the slave side is the terminal.
interface terminal_fifo_if;

   logic        we;
   logic [31:0] addr;
   logic [31:0] data_write;
   logic [31:0] data_read;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output we, addr, data_write, tx_ready,
      input  data_read, tx_data, tx_valid
   );

   modport slave (
      input  we, addr, data_write, tx_ready,
      output data_read, tx_data, tx_valid
   );

endinterface

// File: rtl/terminal_fifo_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with flush, reusable for an RX path.
// A push while full is still accepted if a pop frees a slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_wdata,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   // NOTE: state registers use non-blocking assignments so every always_ff samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/terminal_fifo.sv
// Memory-mapped character terminal: buffered TX byte stream, sticky overflow flag,
// readable status and a shift-register history of bytes delivered to the sink.
module terminal_fifo
   import terminal_fifo_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          DEPTH      = 16,
   parameter int          HIST_BYTES = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   terminal_fifo_if.slave            bus,
   output logic [7:0]                o_terminal_bus,
   output logic [HIST_BYTES*8-1:0]   o_terminal_block
);

   logic                    w_hit;
   logic [7:0]              w_off;
   logic                    w_wr_txdata;
   logic                    w_wr_ctrl;
   logic                    w_flush;
   logic                    w_clr_ovf;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [$clog2(DEPTH):0]  w_count;
   logic [7:0]              w_head;
   status_t                 w_status;
   logic                    w_unused_wdata;

   logic                    r_ovf;
   logic [7:0]              r_terminal_bus;
   logic [HIST_BYTES*8-1:0] r_block;

   assign w_hit       = (bus.addr[31:8] == BASE_ADDR[31:8]);
   assign w_off       = word_offset(bus.addr[7:0]);
   assign w_wr_txdata = bus.we && w_hit && (w_off == TERM_OFF_TXDATA);
   assign w_wr_ctrl   = bus.we && w_hit && (w_off == TERM_OFF_CTRL);
   assign w_flush     = w_wr_ctrl && bus.data_write[CTRL_FLUSH_BIT];
   assign w_clr_ovf   = w_wr_ctrl && bus.data_write[CTRL_CLR_OVF_BIT];
   assign w_pop       = !w_empty && bus.tx_ready;

   assign w_unused_wdata = ^bus.data_write[31:8];

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_wr_txdata),
      .i_pop   (bus.tx_ready),
      .i_flush (w_flush),
      .i_wdata (bus.data_write[7:0]),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.tx_data  = w_head;
   assign bus.tx_valid = !w_empty;

   // A rejected push and a clear on the same edge leave ovf set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
      end else if (w_wr_txdata && w_full && !w_pop) begin
         r_ovf <= 1'b1;
      end else if (w_clr_ovf) begin
         r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_terminal_bus <= 8'h00;
         r_block        <= '0;
      end else if (w_pop) begin
         r_terminal_bus <= w_head;
         r_block        <= {r_block[HIST_BYTES*8-9:0], w_head};
      end
   end

   assign o_terminal_bus   = r_terminal_bus;
   assign o_terminal_block = r_block;

   always_comb begin
      w_status         = '0;
      w_status.count   = 8'(w_count);
      w_status.ovf     = r_ovf;
      w_status.full    = w_full;
      w_status.empty   = w_empty;
   end

   // NOTE: defaulting the output first keeps every path assigned, so no latch is inferred.
   always_comb begin
      bus.data_read = TERM_READ_UNMAPPED;
      if (w_hit) begin
         case (w_off)
            TERM_OFF_TXDATA: bus.data_read = TERM_READ_UNMAPPED;
            TERM_OFF_STATUS: bus.data_read = w_status;
            TERM_OFF_CTRL:   bus.data_read = 32'h0;
            default: begin
               for (int k = 0; k < HIST_BYTES / 4; k++) begin
                  if (w_off == TERM_OFF_HIST + 8'(4 * k)) bus.data_read = r_block[32*k +: 32];
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_terminal_fifo.sv
// Self-checking bench for terminal_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the terminal.
module tb_terminal_fifo;

   localparam int DEPTH      = 16;
   localparam int HIST_BYTES = 16;
   localparam int HW         = HIST_BYTES * 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    terminal_bus;
   logic [HW-1:0] terminal_block;

   terminal_fifo_if bus_if ();

   terminal_fifo #(
      .BASE_ADDR  (32'h0000_0000),
      .DEPTH      (DEPTH),
      .HIST_BYTES (HIST_BYTES)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus_if.slave),
      .o_terminal_bus   (terminal_bus),
      .o_terminal_block (terminal_block)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   byte unsigned  m_q[$];
   logic          m_ovf  = 1'b0;
   logic [7:0]    m_bus  = 8'h00;
   logic [HW-1:0] m_hist = '0;

   task automatic model_edge();
      logic       hit;
      logic [7:0] off;
      logic       push, pop, acc, ctrl;
      byte unsigned b;
      hit  = (bus_if.addr[31:8] == 24'h0);
      off  = bus_if.addr[7:0] & 8'hFC;
      if (reset) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_bus  = 8'h00;
         m_hist = '0;
         return;
      end
      pop  = (m_q.size() > 0) && bus_if.tx_ready;
      push = bus_if.we && hit && (off == 8'h00);
      ctrl = bus_if.we && hit && (off == 8'h08);
      acc  = push && ((m_q.size() < DEPTH) || pop);
      if (pop) begin
         b      = m_q.pop_front();
         m_bus  = b;
         m_hist = (m_hist << 8) | HW'(b);
      end
      if (ctrl && bus_if.data_write[1]) m_q.delete();
      else if (acc) m_q.push_back(bus_if.data_write[7:0]);
      if (push && !acc) m_ovf = 1'b1;
      else if (ctrl && bus_if.data_write[0]) m_ovf = 1'b0;
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [7:0] off;
      off = a[7:0] & 8'hFC;
      if (a[31:8] != 24'h0) return 32'hFFFF_FFFF;
      if (off == 8'h04)
         return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
      if (off == 8'h08) return 32'h0;
      if (off >= 8'h10 && off < 8'(16 + HIST_BYTES)) return m_hist[(int'(off) - 16) * 8 +: 32];
      return 32'hFFFF_FFFF;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_if.we         = 1'b1;
      bus_if.addr       = a;
      bus_if.data_write = d;
      step();
      bus_if.we         = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus_if.we   = 1'b0;
      bus_if.addr = a;
      #1;
      d = bus_if.data_read;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      rd(32'h04, v);
      n_tests++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", v, 32'h1); end
      rd(32'h0C, v);
      n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_unmapped got=%h exp=ffffffff", v); end
      rd(32'h00, v);
      n_tests++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL txdata_read got=%h exp=ffffffff", v); end
      rd(32'h08, v);
      n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL ctrl_read got=%h exp=0", v); end
      n_tests++; if (bus_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus_if.tx_valid); end
      n_tests++; if (terminal_bus !== 8'h00) begin n_fail++; $display("FAIL reset_bus got=%h exp=00", terminal_bus); end
      n_tests++; if (terminal_block !== '0) begin n_fail++; $display("FAIL reset_block got=%h exp=0", terminal_block); end
   endtask

   task automatic test_basic();
      logic [31:0] v;
      bus_if.tx_ready = 1'b0;
      wr(32'h00, 32'h41);
      wr(32'h00, 32'h42);
      n_tests++; if (bus_if.tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", bus_if.tx_valid); end
      n_tests++; if (bus_if.tx_data !== 8'h41) begin n_fail++; $display("FAIL basic_head got=%h exp=41", bus_if.tx_data); end
      rd(32'h04, v);
      n_tests++; if (v !== 32'h0000_0200) begin n_fail++; $display("FAIL basic_status got=%h exp=00000200", v); end
      bus_if.tx_ready = 1'b1;
      step();
      n_tests++; if (bus_if.tx_data !== 8'h42) begin n_fail++; $display("FAIL basic_head2 got=%h exp=42", bus_if.tx_data); end
      n_tests++; if (terminal_bus !== 8'h41) begin n_fail++; $display("FAIL basic_bus1 got=%h exp=41", terminal_bus); end
      step();
      bus_if.tx_ready = 1'b0;
      n_tests++; if (terminal_bus !== 8'h42) begin n_fail++; $display("FAIL basic_bus2 got=%h exp=42", terminal_bus); end
      n_tests++; if (bus_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got=%b exp=0", bus_if.tx_valid); end
      rd(32'h10, v);
      n_tests++; if (v !== 32'h0000_4142) begin n_fail++; $display("FAIL basic_hist got=%h exp=00004142", v); end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      bus_if.tx_ready = 1'b0;
      for (int i = 0; i <= DEPTH; i++) wr(32'h00, 32'h50 + 32'(i));
      rd(32'h04, v);
      n_tests++; if (v !== {16'h0, 8'(DEPTH), 8'h06}) begin n_fail++; $display("FAIL ovf_status got=%h exp=%h", v, {16'h0, 8'(DEPTH), 8'h06}); end
      wr(32'h08, 32'h1);
      rd(32'h04, v);
      n_tests++; if (v !== {16'h0, 8'(DEPTH), 8'h02}) begin n_fail++; $display("FAIL ovf_clear got=%h exp=%h", v, {16'h0, 8'(DEPTH), 8'h02}); end
      bus_if.tx_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'(8'h50 + i)) begin
            n_fail++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, bus_if.tx_valid, bus_if.tx_data, 8'(8'h50 + i));
         end
         step();
      end
      bus_if.tx_ready = 1'b0;
      n_tests++; if (bus_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_extra_byte got=%b exp=0", bus_if.tx_valid); end
      n_tests++; if (terminal_bus !== 8'h5F) begin n_fail++; $display("FAIL ovf_last got=%h exp=5f", terminal_bus); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] v;
      bus_if.tx_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) wr(32'h00, 32'h70 + 32'(i));
      bus_if.tx_ready = 1'b1;
      wr(32'h00, 32'h99);
      bus_if.tx_ready = 1'b0;
      rd(32'h04, v);
      n_tests++; if (v !== {16'h0, 8'(DEPTH), 8'h02}) begin n_fail++; $display("FAIL fullpp_status got=%h exp=%h", v, {16'h0, 8'(DEPTH), 8'h02}); end
      n_tests++; if (terminal_bus !== 8'h70) begin n_fail++; $display("FAIL fullpp_bus got=%h exp=70", terminal_bus); end
      bus_if.tx_ready = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         n_tests++;
         if (bus_if.tx_data !== ((i == DEPTH) ? 8'h99 : 8'(8'h70 + i))) begin
            n_fail++; $display("FAIL fullpp_drain[%0d] got=%h exp=%h", i, bus_if.tx_data, (i == DEPTH) ? 8'h99 : 8'(8'h70 + i));
         end
         step();
      end
      bus_if.tx_ready = 1'b0;
      n_tests++; if (terminal_bus !== 8'h99) begin n_fail++; $display("FAIL fullpp_last got=%h exp=99", terminal_bus); end
   endtask

   task automatic test_flush();
      logic [31:0] v;
      bus_if.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) wr(32'h00, 32'hC1 + 32'(i));
      wr(32'h08, 32'h2);
      n_tests++; if (bus_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", bus_if.tx_valid); end
      rd(32'h04, v);
      n_tests++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_status got=%h exp=00000001", v); end
      wr(32'h00, 32'hA5);
      n_tests++; if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'hA5) begin n_fail++; $display("FAIL flush_refill got=%b/%h exp=1/a5", bus_if.tx_valid, bus_if.tx_data); end
      wr(32'h00, 32'hA6);
      bus_if.tx_ready = 1'b1;
      wr(32'h08, 32'h2);
      bus_if.tx_ready = 1'b0;
      n_tests++; if (terminal_bus !== 8'hA5) begin n_fail++; $display("FAIL flush_handshake got=%h exp=a5", terminal_bus); end
      rd(32'h04, v);
      n_tests++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_hs_status got=%h exp=00000001", v); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      bus_if.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) wr(32'h00, 32'hD0 + 32'(i));
      reset             = 1'b1;
      bus_if.we         = 1'b1;
      bus_if.addr       = 32'h00;
      bus_if.data_write = 32'h33;
      step();
      reset     = 1'b0;
      bus_if.we = 1'b0;
      n_tests++; if (bus_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus_if.tx_valid); end
      n_tests++; if (terminal_bus !== 8'h00) begin n_fail++; $display("FAIL rstmid_bus got=%h exp=00", terminal_bus); end
      n_tests++; if (terminal_block !== '0) begin n_fail++; $display("FAIL rstmid_block got=%h exp=0", terminal_block); end
      rd(32'h04, v);
      n_tests++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL rstmid_status got=%h exp=00000001", v); end
      wr(32'h0000_0100, 32'h40);
      n_tests++; if (bus_if.tx_valid !== 1'b0) begin n_fail++; $display("FAIL window_miss got=%b exp=0", bus_if.tx_valid); end
      rd(32'h04, v);
      n_tests++; if (v !== 32'h0000_0001) begin n_fail++; $display("FAIL window_status got=%h exp=00000001", v); end
   endtask

   function automatic logic [31:0] pick_addr();
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
         0, 1, 2, 3: return 32'h00 | 32'($urandom_range(0, 3));
         4:          return 32'h04 | 32'($urandom_range(0, 3));
         5:          return 32'h08;
         6:          return 32'h0C;
         7:          return 32'h10 + 32'(4 * $urandom_range(0, 3));
         8:          return 32'h0000_0100 | 32'($urandom_range(0, 15));
         default:    return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [31:0] v, a, exp;
      for (int it = 0; it < 600; it++) begin
         reset             = ($urandom_range(0, 99) == 0);
         bus_if.we         = 1'($urandom_range(0, 1));
         bus_if.addr       = pick_addr();
         bus_if.data_write = $urandom;
         bus_if.tx_ready   = ($urandom_range(0, 9) < 4);
         step();
         reset = 1'b0;
         n_tests++; if (bus_if.tx_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid it=%0d got=%b exp=%b", it, bus_if.tx_valid, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            n_tests++; if (bus_if.tx_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_head it=%0d got=%h exp=%h", it, bus_if.tx_data, m_q[0]); end
         end
         n_tests++; if (terminal_bus !== m_bus) begin n_fail++; $display("FAIL rnd_bus it=%0d got=%h exp=%h", it, terminal_bus, m_bus); end
         n_tests++; if (terminal_block !== m_hist) begin n_fail++; $display("FAIL rnd_block it=%0d got=%h exp=%h", it, terminal_block, m_hist); end
         a   = pick_addr();
         exp = model_read(a);
         rd(a, v);
         n_tests++; if (v !== exp) begin n_fail++; $display("FAIL rnd_read it=%0d addr=%h got=%h exp=%h", it, a, v, exp); end
      end
      bus_if.we       = 1'b0;
      bus_if.tx_ready = 1'b0;
   endtask

   initial begin
      bus_if.we         = 1'b0;
      bus_if.addr       = 32'h0;
      bus_if.data_write = 32'h0;
      bus_if.tx_ready   = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
